// File: rtl/rhs_cfg_pkg.sv
// Shared constants for the RHS configuration register block:
// register byte offsets, field widths, ctrl bit indices, AXI resp codes.
package rhs_cfg_pkg;

    // Register byte offsets (only [5:2] are decoded)
    localparam logic [5:0] RHS_REG_CTRL      = 6'h00;
    localparam logic [5:0] RHS_REG_STIM_MAG  = 6'h04;
    localparam logic [5:0] RHS_REG_PKT_LEN   = 6'h08;
    localparam logic [5:0] RHS_REG_ZCHECK    = 6'h0C;
    localparam logic [5:0] RHS_REG_STIM_CH   = 6'h10;
    localparam logic [5:0] RHS_REG_PULSE_W   = 6'h14;
    localparam logic [5:0] RHS_REG_IPD       = 6'h18;
    localparam logic [5:0] RHS_REG_NUM_PULSE = 6'h1C;
    localparam logic [5:0] RHS_REG_STATUS    = 6'h20;

    // Field widths
    localparam int CTRL_W      = 6;
    localparam int STIM_MAG_W  = 32;
    localparam int PKT_LEN_W   = 8;
    localparam int ZCHECK_W    = 10;
    localparam int STIM_CH_W   = 11;
    localparam int PULSE_W_W   = 16;
    localparam int IPD_W       = 16;
    localparam int NUM_PULSE_W = 8;
    localparam int STATUS_W    = 3;

    // ctrl_o bit indices
    localparam int CTRL_GO       = 0;
    localparam int CTRL_INIT     = 1;
    localparam int CTRL_MAG_SET  = 2;
    localparam int CTRL_STIM_EN  = 3;
    localparam int CTRL_RSVD     = 4;
    localparam int CTRL_LOOPBACK = 5;

    // status_i bit indices
    localparam int STAT_BUSY        = 0;
    localparam int STAT_STIM_ACTIVE = 1;
    localparam int STAT_ERROR       = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge of new data over an old word
    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rhs_axil_cfg_regs_axil_wr_join.sv
// AXI-Lite AW/W skid-and-join: captures each beat independently and
// raises commit_o while both are held and no response is outstanding.
// Ports: clk/rst; AW and W channels; resp_busy_i (bvalid),
// resp_done_i (B handshake); commit_o with held addr/data/strb.
module axil_wr_join #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    input  logic                resp_busy_i,
    input  logic                resp_done_i,
    output logic                commit_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W/8-1:0] strb_o
);

    logic                aw_full_q, aw_full_d;
    logic                w_full_q, w_full_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;

    // Beats stay held through the response so only one write is in flight
    assign awready  = !aw_full_q;
    assign wready   = !w_full_q;
    assign commit_o = aw_full_q && w_full_q && !resp_busy_i;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign strb_o   = strb_q;

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (resp_done_i) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_full_d = 1'b1;
                addr_d    = awaddr;
            end
            if (wvalid && wready) begin
                w_full_d = 1'b1;
                data_d   = wdata;
                strb_d   = wstrb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/rhs_axil_cfg_regs.sv
// AXI4-Lite register file for RHS stim/acquisition config; status at 0x20.
// Ports: aclk/areset, AXI-Lite slave, config outputs, status_i, cfg_wr_o.
// Macro RHS_CFG_SLVERR_EN: SLVERR on unmapped access / locked writes.
module rhs_axil_cfg_regs
    import rhs_cfg_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ADDR_W-1:0]      s_axil_awaddr,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [DATA_W-1:0]      s_axil_wdata,
    input  logic [DATA_W/8-1:0]    s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_W-1:0]      s_axil_araddr,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [DATA_W-1:0]      s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [CTRL_W-1:0]      ctrl_o,
    output logic [STIM_MAG_W-1:0]  stim_mag_o,
    output logic [PKT_LEN_W-1:0]   pkt_len_o,
    output logic [ZCHECK_W-1:0]    zcheck_o,
    output logic [STIM_CH_W-1:0]   stim_ch_o,
    output logic [PULSE_W_W-1:0]   pulse_w_o,
    output logic [IPD_W-1:0]       ipd_o,
    output logic [NUM_PULSE_W-1:0] num_pulse_o,
    input  logic [STATUS_W-1:0]    status_i,
    output logic                   cfg_wr_o
);

    localparam logic [3:0] IDX_CTRL   = RHS_REG_CTRL[5:2];
    localparam logic [3:0] IDX_MAG    = RHS_REG_STIM_MAG[5:2];
    localparam logic [3:0] IDX_PKT    = RHS_REG_PKT_LEN[5:2];
    localparam logic [3:0] IDX_ZCHK   = RHS_REG_ZCHECK[5:2];
    localparam logic [3:0] IDX_CH     = RHS_REG_STIM_CH[5:2];
    localparam logic [3:0] IDX_PW     = RHS_REG_PULSE_W[5:2];
    localparam logic [3:0] IDX_IPD    = RHS_REG_IPD[5:2];
    localparam logic [3:0] IDX_NPULSE = RHS_REG_NUM_PULSE[5:2];
    localparam logic [3:0] IDX_STATUS = RHS_REG_STATUS[5:2];

    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic [STIM_MAG_W-1:0]  stim_mag_q, stim_mag_d;
    logic [PKT_LEN_W-1:0]   pkt_len_q, pkt_len_d;
    logic [ZCHECK_W-1:0]    zcheck_q, zcheck_d;
    logic [STIM_CH_W-1:0]   stim_ch_q, stim_ch_d;
    logic [PULSE_W_W-1:0]   pulse_w_q, pulse_w_d;
    logic [IPD_W-1:0]       ipd_q, ipd_d;
    logic [NUM_PULSE_W-1:0] num_pulse_q, num_pulse_d;
    logic                   cfg_wr_q, cfg_wr_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic                   commit;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [DATA_W/8-1:0]    wr_strb;
    logic [3:0]             wr_off;
    logic [3:0]             rd_off;
    logic [31:0]            wr_val;
    logic                   wr_err;
    logic                   rd_err;
    logic                   ar_hs;
    logic [31:0]            reg_rd [16];
    logic                   unused_addr;

    axil_wr_join #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_join (
        .clk         (aclk),
        .rst         (areset),
        .awaddr      (s_axil_awaddr),
        .awvalid     (s_axil_awvalid),
        .awready     (s_axil_awready),
        .wdata       (s_axil_wdata),
        .wstrb       (s_axil_wstrb),
        .wvalid      (s_axil_wvalid),
        .wready      (s_axil_wready),
        .resp_busy_i (bvalid_q),
        .resp_done_i (bvalid_q && s_axil_bready),
        .commit_o    (commit),
        .addr_o      (wr_addr),
        .data_o      (wr_data),
        .strb_o      (wr_strb)
    );

    assign wr_off      = wr_addr[5:2];
    assign rd_off      = s_axil_araddr[5:2];
    assign unused_addr = ^{wr_addr[1:0], s_axil_araddr[1:0]};
    assign ar_hs       = s_axil_arvalid && s_axil_arready;

    // Zero-extended view of every offset, shared by reads and
    // the read-modify-write used for partial strobes
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            reg_rd[i] = '0;
        end
        reg_rd[IDX_CTRL]   = 32'(ctrl_q);
        reg_rd[IDX_MAG]    = 32'(stim_mag_q);
        reg_rd[IDX_PKT]    = 32'(pkt_len_q);
        reg_rd[IDX_ZCHK]   = 32'(zcheck_q);
        reg_rd[IDX_CH]     = 32'(stim_ch_q);
        reg_rd[IDX_PW]     = 32'(pulse_w_q);
        reg_rd[IDX_IPD]    = 32'(ipd_q);
        reg_rd[IDX_NPULSE] = 32'(num_pulse_q);
        reg_rd[IDX_STATUS] = 32'(status_i);
    end

    assign wr_val = apply_strb(reg_rd[wr_off], wr_data, wr_strb);

`ifdef RHS_CFG_SLVERR_EN
    // Stim parameters are locked while a stimulation is running
    assign wr_err = (wr_off > IDX_STATUS)
                 || (status_i[STAT_STIM_ACTIVE]
                     && wr_off >= IDX_MAG
                     && wr_off <= IDX_NPULSE);
    assign rd_err = rd_off > IDX_STATUS;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    always_comb begin
        ctrl_d      = ctrl_q;
        stim_mag_d  = stim_mag_q;
        pkt_len_d   = pkt_len_q;
        zcheck_d    = zcheck_q;
        stim_ch_d   = stim_ch_q;
        pulse_w_d   = pulse_w_q;
        ipd_d       = ipd_q;
        num_pulse_d = num_pulse_q;
        cfg_wr_d    = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
            cfg_wr_d = !wr_err;
            if (!wr_err) begin
                case (wr_off)
                    IDX_CTRL:   ctrl_d      = wr_val[CTRL_W-1:0];
                    IDX_MAG:    stim_mag_d  = wr_val[STIM_MAG_W-1:0];
                    IDX_PKT:    pkt_len_d   = wr_val[PKT_LEN_W-1:0];
                    IDX_ZCHK:   zcheck_d    = wr_val[ZCHECK_W-1:0];
                    IDX_CH:     stim_ch_d   = wr_val[STIM_CH_W-1:0];
                    IDX_PW:     pulse_w_d   = wr_val[PULSE_W_W-1:0];
                    IDX_IPD:    ipd_d       = wr_val[IPD_W-1:0];
                    IDX_NPULSE: num_pulse_d = wr_val[NUM_PULSE_W-1:0];
                    default:    ;
                endcase
            end
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read samples the pre-edge registers, so a same-cycle
    // commit to the same offset returns the old value
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = rd_err ? '0 : reg_rd[rd_off];
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctrl_q      <= '0;
            stim_mag_q  <= '0;
            pkt_len_q   <= '0;
            zcheck_q    <= '0;
            stim_ch_q   <= '0;
            pulse_w_q   <= '0;
            ipd_q       <= '0;
            num_pulse_q <= '0;
            cfg_wr_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            stim_mag_q  <= stim_mag_d;
            pkt_len_q   <= pkt_len_d;
            zcheck_q    <= zcheck_d;
            stim_ch_q   <= stim_ch_d;
            pulse_w_q   <= pulse_w_d;
            ipd_q       <= ipd_d;
            num_pulse_q <= num_pulse_d;
            cfg_wr_q    <= cfg_wr_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
        end
    end

    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign cfg_wr_o       = cfg_wr_q;
    assign ctrl_o         = ctrl_q;
    assign stim_mag_o     = stim_mag_q;
    assign pkt_len_o      = pkt_len_q;
    assign zcheck_o       = zcheck_q;
    assign stim_ch_o      = stim_ch_q;
    assign pulse_w_o      = pulse_w_q;
    assign ipd_o          = ipd_q;
    assign num_pulse_o    = num_pulse_q;

endmodule
